// File: rtl/tdc_arb_pkg.sv
// -----------------------------------------------------------------------------
// tdc_arb_pkg
// Shared types and helpers for the TDC event arbiter.
//   arb_state_e        : arbiter FSM states (ARB decides, WRITE is the write cycle)
//   DATA_W_DEFAULT     : default TDC event word width (equals FIFO data width)
//   DROP_CNT_W_DEFAULT : default width of the per-channel drop counters
//   next_rr_idx()      : next round-robin index with wrap-around
// -----------------------------------------------------------------------------
package tdc_arb_pkg;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    WRITE = 1'b1
  } arb_state_e;

  localparam int DATA_W_DEFAULT     = 68;
  localparam int DROP_CNT_W_DEFAULT = 16;

  // Index that follows idx in a ring of n entries.
  function automatic int next_rr_idx(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/tdc_rr_select.sv
// -----------------------------------------------------------------------------
// tdc_rr_select
// Combinational round-robin picker. Finds the first set request bit searching
// upward from ptr+1, wrapping modulo NUM_CHAN.
// Ports:
//   req       in  [NUM_CHAN]  request vector (one bit per channel)
//   ptr       in  [IDX_W]     index served last
//   grant_idx out [IDX_W]     selected channel (0 when nothing requested)
//   any_req   out 1           at least one request present
// -----------------------------------------------------------------------------
module tdc_rr_select
  import tdc_arb_pkg::*;
#(
  parameter int NUM_CHAN = 2,
  parameter int IDX_W    = $clog2(NUM_CHAN)
) (
  input  logic [NUM_CHAN-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                any_req
);

  always_comb begin
    int cand;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise a path that skips it infers a latch.
    grant_idx = '0;
    any_req   = 1'b0;
    cand      = int'(ptr);
    for (int k = 0; k < NUM_CHAN; k++) begin
      cand = next_rr_idx(cand, NUM_CHAN);
      if (req[cand] && !any_req) begin
        grant_idx = IDX_W'(cand);
        any_req   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdc_event_arbiter.sv
// -----------------------------------------------------------------------------
// tdc_event_arbiter
// Shares the single event-FIFO write port between NUM_CHAN TDC channels. Each
// channel owns a one-entry holding buffer; occupied buffers are served
// round-robin, one FIFO word at most every two cycles, honouring fifo_full.
// Events that arrive while a channel's buffer is still occupied are lost and
// counted per channel.
//
// Optional feature: define TDC_ARB_DROP_CNT_EN to build the saturating drop
// counters. Without it drop_count is tied to 0 and clear_drops is ignored.
//
// Ports:
//   clk          in  1                     system clock, rising edge
//   reset        in  1                     synchronous, active-high reset
//   chan_valid   in  [NUM_CHAN]            one-cycle event strobe per channel
//   chan_data    in  [NUM_CHAN*DATA_W]     event words, channel i at [i*DATA_W +: DATA_W]
//   chan_ack     out [NUM_CHAN]            pulse the cycle after an event is captured
//   fifo_full    in  1                     FIFO full flag, sampled only in ARB
//   fifo_wdata   out [DATA_W]              FIFO write data, held between writes
//   fifo_write   out 1                     FIFO write strobe, one cycle per word
//   grant_onehot out [NUM_CHAN]            source of the current write, else 0
//   clear_drops  in  1                     synchronous clear of all drop counters
//   drop_count   out [NUM_CHAN*DROP_CNT_W] per-channel saturating drop counters
// -----------------------------------------------------------------------------
module tdc_event_arbiter
  import tdc_arb_pkg::*;
#(
  parameter int NUM_CHAN   = 2,
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int DROP_CNT_W = DROP_CNT_W_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CHAN-1:0]          chan_valid,
  input  logic [NUM_CHAN*DATA_W-1:0]   chan_data,
  output logic [NUM_CHAN-1:0]          chan_ack,
  input  logic                         fifo_full,
  output logic [DATA_W-1:0]            fifo_wdata,
  output logic                         fifo_write,
  output logic [NUM_CHAN-1:0]          grant_onehot,
  input  logic                         clear_drops,
  output logic [NUM_CHAN*DROP_CNT_W-1:0] drop_count
);

  localparam int IDX_W = $clog2(NUM_CHAN);

  arb_state_e          state_q, state_d;
  logic [NUM_CHAN-1:0] buf_full;
  logic [DATA_W-1:0]   buf_data [NUM_CHAN];
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    sel_idx;
  logic                any_req;
  logic                issue;     // ARB decided to write buffer sel_idx this edge
  logic [NUM_CHAN-1:0] drain;     // buffer emptied at this edge
  logic [NUM_CHAN-1:0] capture;   // event latched into its buffer at this edge
  logic [NUM_CHAN-1:0] drop_evt;  // event lost: buffer occupied and not draining

  tdc_rr_select #(
    .NUM_CHAN (NUM_CHAN),
    .IDX_W    (IDX_W)
  ) u_rr_select (
    .req       (buf_full),
    .ptr       (rr_ptr),
    .grant_idx (sel_idx),
    .any_req   (any_req)
  );

  // ---------------------------------------------------------------------------
  // FSM: ARB looks at fifo_full and the buffers; WRITE is the cycle the word
  // is presented, giving the FIFO one cycle to update fifo_full.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: clocked state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    if (reset) state_q <= ARB;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      ARB: begin
        if (!fifo_full && any_req) begin
          issue   = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE:   state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // A buffer being drained this edge may take a new word at the same edge.
  always_comb begin
    drain = '0;
    if (issue) drain[sel_idx] = 1'b1;
    capture  = chan_valid & (~buf_full | drain);
    drop_evt = chan_valid & buf_full & ~drain;
  end

  // ---------------------------------------------------------------------------
  // Holding buffers and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_full     <= '0;
      rr_ptr       <= IDX_W'(NUM_CHAN - 1);
      chan_ack     <= '0;
      fifo_write   <= 1'b0;
      fifo_wdata   <= '0;
      grant_onehot <= '0;
      // NOTE: the buffer words are cleared as well so fifo_wdata can never
      // expose stale data after reset; buf_full alone qualifies them.
      for (int i = 0; i < NUM_CHAN; i++) buf_data[i] <= '0;
    end else begin
      chan_ack     <= capture;
      fifo_write   <= issue;
      grant_onehot <= issue ? (NUM_CHAN'(1) << sel_idx) : '0;
      if (issue) begin
        fifo_wdata <= buf_data[sel_idx];
        rr_ptr     <= sel_idx;
      end
      for (int i = 0; i < NUM_CHAN; i++) begin
        if (capture[i]) buf_data[i] <= chan_data[i*DATA_W +: DATA_W];
      end
      buf_full <= (buf_full & ~drain) | capture;
    end
  end

  // ---------------------------------------------------------------------------
  // Drop counters
  // ---------------------------------------------------------------------------
`ifdef TDC_ARB_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt [NUM_CHAN];

  // clear_drops wins over a same-cycle drop; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (reset || clear_drops) begin
      for (int i = 0; i < NUM_CHAN; i++) drop_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        if (drop_evt[i] && (drop_cnt[i] != '1)) drop_cnt[i] <= drop_cnt[i] + DROP_CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_CHAN; g++) begin : g_drop_out
    assign drop_count[g*DROP_CNT_W +: DROP_CNT_W] = drop_cnt[g];
  end
`else
  logic unused_drop_inputs;

  assign drop_count         = '0;
  assign unused_drop_inputs = ^{clear_drops, drop_evt};
`endif

endmodule

// File: tb/tb_tdc_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tdc_event_arbiter
// Directed bench for tdc_event_arbiter (NUM_CHAN=2, DATA_W=68, DROP_CNT_W=16).
// Inputs change and outputs are checked 1 time unit after each rising edge.
// Drop-counter expectations follow TDC_ARB_DROP_CNT_EN.
// -----------------------------------------------------------------------------
module tb_tdc_event_arbiter;

  localparam int NUM_CHAN   = 2;
  localparam int DATA_W     = 68;
  localparam int DROP_CNT_W = 16;

`ifdef TDC_ARB_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
  localparam int N_SAT  = 70000;
`else
  localparam bit CNT_EN = 1'b0;
  localparam int N_SAT  = 100;
`endif

  logic                           clk = 1'b0;
  logic                           reset;
  logic [NUM_CHAN-1:0]            chan_valid;
  logic [NUM_CHAN*DATA_W-1:0]     chan_data;
  logic [NUM_CHAN-1:0]            chan_ack;
  logic                           fifo_full;
  logic [DATA_W-1:0]              fifo_wdata;
  logic                           fifo_write;
  logic [NUM_CHAN-1:0]            grant_onehot;
  logic                           clear_drops;
  logic [NUM_CHAN*DROP_CNT_W-1:0] drop_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tdc_event_arbiter #(
    .NUM_CHAN   (NUM_CHAN),
    .DATA_W     (DATA_W),
    .DROP_CNT_W (DROP_CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .chan_valid   (chan_valid),
    .chan_data    (chan_data),
    .chan_ack     (chan_ack),
    .fifo_full    (fifo_full),
    .fifo_wdata   (fifo_wdata),
    .fifo_write   (fifo_write),
    .grant_onehot (grant_onehot),
    .clear_drops  (clear_drops),
    .drop_count   (drop_count)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write cycle: strobe, data and source all checked together.
  task automatic check_write(input string tag, input logic [DATA_W-1:0] data, input logic [NUM_CHAN-1:0] gnt);
    check({tag, ".write"}, 128'(fifo_write), 128'(1'b1));
    check({tag, ".wdata"}, 128'(fifo_wdata), 128'(data));
    check({tag, ".grant"}, 128'(grant_onehot), 128'(gnt));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".write"}, 128'(fifo_write), 128'(1'b0));
    check({tag, ".grant"}, 128'(grant_onehot), 128'(0));
  endtask

  function automatic logic [DROP_CNT_W-1:0] drops(input int ch);
    return drop_count[ch*DROP_CNT_W +: DROP_CNT_W];
  endfunction

  // Counts writes over n cycles with the inputs left as they are.
  task automatic count_writes(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (fifo_write) cnt++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    reset       = 1'b1;
    chan_valid  = '0;
    chan_data   = '0;
    fifo_full   = 1'b0;
    clear_drops = 1'b0;
    tick();
    tick();

    // ---- reset state ------------------------------------------------------
    check("rst.ack",   128'(chan_ack), 128'(0));
    check("rst.write", 128'(fifo_write), 128'(0));
    check("rst.wdata", 128'(fifo_wdata), 128'(0));
    check("rst.grant", 128'(grant_onehot), 128'(0));
    check("rst.drops", 128'(drop_count), 128'(0));
    reset = 1'b0;

    // ---- single event, latency N+2 -------------------------------------------
    chan_valid          = 2'b01;
    chan_data[0 +: 68]  = 68'h0AA;
    tick();
    chan_valid = '0;
    check("t1.ack", 128'(chan_ack), 128'(2'b01));
    check("t1.n1_write", 128'(fifo_write), 128'(0));
    tick();
    check_write("t1.w", 68'h0AA, 2'b01);
    check("t1.ack_clr", 128'(chan_ack), 128'(0));
    tick();
    check_idle("t1.after");
    check("t1.wdata_hold", 128'(fifo_wdata), 128'(68'h0AA));

    // ---- both channels at once, round-robin order ----------------------------
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chan_valid          = 2'b11;
    chan_data[0 +: 68]  = 68'h111;
    chan_data[68 +: 68] = 68'h222;
    tick();
    chan_valid = '0;
    check("t2.ack", 128'(chan_ack), 128'(2'b11));
    tick();
    check_write("t2.w0", 68'h111, 2'b01);
    tick();
    check_idle("t2.gap");
    tick();
    check_write("t2.w1", 68'h222, 2'b10);
    tick();
    check_idle("t2.idle");
    chan_valid          = 2'b11;
    chan_data[0 +: 68]  = 68'h333;
    chan_data[68 +: 68] = 68'h444;
    tick();
    chan_valid = '0;
    check("t2.ack2", 128'(chan_ack), 128'(2'b11));
    tick();
    check_write("t2.w2", 68'h333, 2'b01);
    tick();
    check_idle("t2.gap2");
    tick();
    check_write("t2.w3", 68'h444, 2'b10);
    tick();

    // ---- overrun while FIFO full ---------------------------------------------
    fifo_full          = 1'b1;
    chan_valid         = 2'b01;
    chan_data[0 +: 68] = 68'h501;
    tick();
    check("t3.ack_first", 128'(chan_ack), 128'(2'b01));
    for (int i = 1; i < 5; i++) begin
      chan_data[0 +: 68] = 68'(68'h501 + i);
      tick();
      check("t3.ack_drop", 128'(chan_ack), 128'(0));
      check("t3.no_write", 128'(fifo_write), 128'(0));
    end
    chan_valid = '0;
    count_writes(15, n);
    check("t3.full_writes", 128'(n), 128'(0));
    check("t3.drop0", 128'(drops(0)), CNT_EN ? 128'(4) : 128'(0));
    check("t3.drop1", 128'(drops(1)), 128'(0));
    fifo_full = 1'b0;
    tick();
    check_write("t3.w", 68'h501, 2'b01);
    count_writes(4, n);
    check("t3.extra_writes", 128'(n), 128'(0));

    // ---- capture into a buffer during its drain cycle ------------------------
    chan_valid          = 2'b10;
    chan_data[68 +: 68] = 68'h611;
    tick();
    check("t4.ack0", 128'(chan_ack), 128'(2'b10));
    chan_data[68 +: 68] = 68'h622;   // strobe in the cycle that drains buf_1
    tick();
    chan_valid = '0;
    check_write("t4.w0", 68'h611, 2'b10);
    check("t4.ack1", 128'(chan_ack), 128'(2'b10));
    tick();
    check_idle("t4.gap");
    tick();
    check_write("t4.w1", 68'h622, 2'b10);
    chan_valid          = 2'b10;     // strobe in the WRITE cycle
    chan_data[68 +: 68] = 68'h633;
    tick();
    chan_valid = '0;
    check("t4.ack2", 128'(chan_ack), 128'(2'b10));
    check_idle("t4.gap2");
    tick();
    check_write("t4.w2", 68'h633, 2'b10);
    check("t4.drop1", 128'(drops(1)), 128'(0));
    tick();

    // ---- drop counter saturation and clear -----------------------------------
    fifo_full          = 1'b1;
    chan_valid         = 2'b01;
    chan_data[0 +: 68] = 68'h701;
    for (int i = 0; i < N_SAT + 1; i++) tick();
    check("t5.sat", 128'(drops(0)), CNT_EN ? 128'(16'hFFFF) : 128'(0));
    clear_drops = 1'b1;              // same-cycle drop must not survive the clear
    tick();
    clear_drops = 1'b0;
    check("t5.clear", 128'(drops(0)), 128'(0));
    tick();
    check("t5.after_clear", 128'(drops(0)), CNT_EN ? 128'(1) : 128'(0));
    check("t5.full_write", 128'(fifo_write), 128'(0));

    // ---- reset during a write discards everything ----------------------------
    chan_valid          = 2'b10;
    chan_data[68 +: 68] = 68'h801;
    tick();
    chan_valid = '0;
    check("t6.ack", 128'(chan_ack), 128'(2'b10));
    fifo_full = 1'b0;
    tick();
    check_write("t6.w", 68'h701, 2'b01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("t6.rst");
    check("t6.wdata", 128'(fifo_wdata), 128'(0));
    check("t6.drops", 128'(drop_count), 128'(0));
    count_writes(4, n);
    check("t6.discarded", 128'(n), 128'(0));
    chan_valid         = 2'b01;
    chan_data[0 +: 68] = 68'h9AB;
    tick();
    chan_valid = '0;
    check("t6.ack2", 128'(chan_ack), 128'(2'b01));
    tick();
    check_write("t6.w2", 68'h9AB, 2'b01);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
